// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and constants for the sequential Booth multiplier.
//               BOOTH_RADIX4_EN selects radix-4 (modified Booth) recoding.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        NOP    = 3'd0,
        ADD_M  = 3'd1,
        SUB_M  = 3'd2,
        ADD_2M = 3'd3,
        SUB_2M = 3'd4
    } booth_op_t;

`ifdef BOOTH_RADIX4_EN
    localparam int RADIX_SHIFT = 2;
    localparam int RECODE_BITS = 3;
`else
    localparam int RADIX_SHIFT = 1;
    localparam int RECODE_BITS = 2;
`endif

endpackage
`default_nettype wire

// File: rtl/booth_recoder.sv
`default_nettype none
// ============================================================================
// Module      : booth_recoder
// Description : Combinational Booth recoder; radix-4 when BOOTH_RADIX4_EN is
//               defined ({Q[i+1],Q[i],Q[i-1]}), radix-2 otherwise ({Q[i],Q[i-1]}).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_recoder
    import booth_pkg::*;
(
    input  logic [RECODE_BITS-1:0] i_bits,
    output booth_op_t              o_op
);

    always_comb begin
        o_op = NOP;
`ifdef BOOTH_RADIX4_EN
        case (i_bits)
            3'b001, 3'b010: o_op = ADD_M;
            3'b011:         o_op = ADD_2M;
            3'b100:         o_op = SUB_2M;
            3'b101, 3'b110: o_op = SUB_M;
            default:        o_op = NOP;
        endcase
`else
        case (i_bits)
            2'b01:   o_op = ADD_M;
            2'b10:   o_op = SUB_M;
            default: o_op = NOP;
        endcase
`endif
    end

endmodule
`default_nettype wire

// File: rtl/seq_booth_mult.sv
`default_nettype none
// ============================================================================
// Module      : seq_booth_mult
// Description : Sequential signed Booth multiplier with valid/ready handshakes.
//               BOOTH_RADIX4_EN builds radix-4 (WIDTH/2 iterations), else radix-2.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_booth_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // Extra guard bits keep +-M (and +-2M) exact when M = -2^(WIDTH-1)
    localparam int c_ACC_W = WIDTH + RADIX_SHIFT;
    localparam int c_N     = WIDTH / RADIX_SHIFT;
    localparam int c_CNT_W = (c_N > 2) ? $clog2(c_N) : 1;
    localparam int c_SR_W  = c_ACC_W + WIDTH + 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width_range
        $error("seq_booth_mult: WIDTH must be in 4..32");
    end

`ifdef BOOTH_RADIX4_EN
    if (WIDTH % 2 != 0) begin : g_odd_width
        $error("seq_booth_mult: radix-4 build requires even WIDTH");
    end
`endif

    state_t                 r_state;
    logic [WIDTH-1:0]       r_m;
    logic [WIDTH-1:0]       r_q;
    logic                   r_qm1;
    logic [c_ACC_W-1:0]     r_acc;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]     r_product;

    logic [RECODE_BITS-1:0] w_recode_bits;
    booth_op_t              w_op;
    logic [c_ACC_W-1:0]     w_m_ext;
    logic [c_ACC_W-1:0]     w_addend;
    logic [c_ACC_W-1:0]     w_sum;
    logic [c_SR_W-1:0]      w_shifted;

    assign w_recode_bits = {r_q[RECODE_BITS-2:0], r_qm1};

    booth_recoder u_recoder (
        .i_bits (w_recode_bits),
        .o_op   (w_op)
    );

    assign w_m_ext = {{RADIX_SHIFT{r_m[WIDTH-1]}}, r_m};

    always_comb begin
        w_addend = '0;
        case (w_op)
            ADD_M:   w_addend = w_m_ext;
            SUB_M:   w_addend = -w_m_ext;
            ADD_2M:  w_addend = w_m_ext << 1;
            SUB_2M:  w_addend = -(w_m_ext << 1);
            default: w_addend = '0;
        endcase
    end

    assign w_sum     = r_acc + w_addend;
    // {A, Q, Q[-1]} shifts as one signed register
    assign w_shifted = $signed({w_sum, r_q, r_qm1}) >>> RADIX_SHIFT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_m       <= '0;
            r_q       <= '0;
            r_qm1     <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_m     <= multiplicand;
                        r_q     <= multiplier;
                        r_qm1   <= 1'b0;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_shifted[c_SR_W-1 -: c_ACC_W];
                    r_q   <= w_shifted[WIDTH:1];
                    r_qm1 <= w_shifted[0];
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_product <= w_shifted[2*WIDTH:1];
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = r_product;

endmodule
`default_nettype wire
